// File: rtl/hv_scan_bist_pkg.sv
// Shared types and default sizes for the HV scan-register BIST responder.
// HV_SCAN_REG_NUM must match the upstream BIST controller's register count.
package hv_scan_bist_pkg;

  localparam int HV_SCAN_REG_NUM_DEF = 8;
  localparam int HV_SCAN_REG_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/hv_scan_word_chk.sv
// Integrity check of one scan register: the shadow must be the exact inverse
// of the data word, and the stored bit must equal the data word's even parity.
module hv_scan_word_chk #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] data_n,
  input  logic         par,
  output logic         fail
);

  assign fail = (data != ~data_n) | ((^data) != par);

endmodule

// File: rtl/hv_scan_reg_bist.sv
// Scan-register BIST responder: reads one register per request, checks it and
// acks with a pass/fail flag. Optional HV_SCAN_BIST_ERR_INJ_EN adds error injection.
module hv_scan_reg_bist
  import hv_scan_bist_pkg::*;
#(
  parameter int  HV_SCAN_REG_NUM = HV_SCAN_REG_NUM_DEF,
  parameter int  HV_SCAN_REG_W   = HV_SCAN_REG_W_DEF,
  parameter int  RD_LAT          = 1,
  parameter int  ERR_CNT_W       = 4,
  localparam int IDX_W           = $clog2(HV_SCAN_REG_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bist_en,
  input  logic                     i_bist_scan_reg_req,
  output logic                     o_scan_reg_bist_ack,
  output logic                     o_scan_reg_bist_err,
  output logic                     o_scan_rd_en,
  output logic [IDX_W-1:0]         o_scan_rd_addr,
  input  logic [HV_SCAN_REG_W-1:0] i_scan_rd_data,
  input  logic [HV_SCAN_REG_W-1:0] i_scan_rd_data_n,
  input  logic                     i_scan_rd_par,
`ifdef HV_SCAN_BIST_ERR_INJ_EN
  input  logic                     i_err_inj_en,
  input  logic [IDX_W-1:0]         i_err_inj_idx,
`endif
  output logic [IDX_W-1:0]         o_err_first_idx,
  output logic                     o_err_first_vld,
  output logic [ERR_CNT_W-1:0]     o_err_cnt
);

  localparam int                   LAT_W    = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0]     LAT_LOAD = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0]     LAT_ONE  = LAT_W'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(HV_SCAN_REG_NUM - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  scan_state_e          state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [LAT_W-1:0]     lat_cnt_reg, lat_cnt_next;
  logic                 rd_en_reg, rd_en_next;
  logic [IDX_W-1:0]     rd_addr_reg, rd_addr_next;
  logic                 ack_reg, ack_next;
  logic                 err_reg, err_next;
  logic [IDX_W-1:0]     first_idx_reg, first_idx_next;
  logic                 first_vld_reg, first_vld_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic [HV_SCAN_REG_W-1:0] inj_mask;
  logic [HV_SCAN_REG_W-1:0] chk_data;
  logic                     chk_fail;

`ifdef HV_SCAN_BIST_ERR_INJ_EN
  // Flipping bit 0 breaks both the shadow and the parity relation.
  assign inj_mask = {{(HV_SCAN_REG_W-1){1'b0}}, (i_err_inj_en && (i_err_inj_idx == idx_reg))};
`else
  assign inj_mask = '0;
`endif

  assign chk_data = i_scan_rd_data ^ inj_mask;

  hv_scan_word_chk #(
    .W (HV_SCAN_REG_W)
  ) u_word_chk (
    .data   (chk_data),
    .data_n (i_scan_rd_data_n),
    .par    (i_scan_rd_par),
    .fail   (chk_fail)
  );

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    lat_cnt_next   = lat_cnt_reg;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    first_idx_next = first_idx_reg;
    first_vld_next = first_vld_reg;
    err_cnt_next   = err_cnt_reg;

    if (!i_bist_en) begin
      state_next     = IDLE;
      idx_next       = '0;
      lat_cnt_next   = '0;
      rd_addr_next   = '0;
      first_idx_next = '0;
      first_vld_next = 1'b0;
      err_cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_bist_scan_reg_req) begin
            state_next   = RD;
            rd_en_next   = 1'b1;
            rd_addr_next = idx_reg;
          end
        end
        RD: begin
          state_next   = WAIT;
          lat_cnt_next = LAT_LOAD;
        end
        WAIT: begin
          // Bank data is valid only on the final wait cycle.
          if (lat_cnt_reg == LAT_ONE) begin
            state_next = ACK;
            ack_next   = 1'b1;
            err_next   = chk_fail;
          end else begin
            lat_cnt_next = lat_cnt_reg - LAT_ONE;
          end
        end
        ACK: begin
          state_next = IDLE;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
          if (err_reg) begin
            if (!first_vld_reg) begin
              first_vld_next = 1'b1;
              first_idx_next = idx_reg;
            end
            if (err_cnt_reg != CNT_MAX) begin
              err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      lat_cnt_reg   <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      first_idx_reg <= '0;
      first_vld_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      lat_cnt_reg   <= lat_cnt_next;
      rd_en_reg     <= rd_en_next;
      rd_addr_reg   <= rd_addr_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      first_idx_reg <= first_idx_next;
      first_vld_reg <= first_vld_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign o_scan_reg_bist_ack = ack_reg;
  assign o_scan_reg_bist_err = err_reg;
  assign o_scan_rd_en        = rd_en_reg;
  assign o_scan_rd_addr      = rd_addr_reg;
  assign o_err_first_idx     = first_idx_reg;
  assign o_err_first_vld     = first_vld_reg;
  assign o_err_cnt           = err_cnt_reg;

endmodule

// File: tb/tb_hv_scan_reg_bist.sv
// Bench for hv_scan_reg_bist: table-driven register walks on an RD_LAT=1 instance
// plus hand sequences for abort and an RD_LAT=3 instance.
module tb_hv_scan_reg_bist;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic en1, req1, ack1, err1, rd_en1, p1, fvld1;
  logic [IW-1:0] addr1, fidx1;
  logic [W-1:0]  d1, dn1;
  logic [CW-1:0] cnt1;

  logic en3, req3, ack3, err3, rd_en3, p3, fvld3;
  logic [IW-1:0] addr3, fidx3;
  logic [W-1:0]  d3, dn3;
  logic [CW-1:0] cnt3;

`ifdef HV_SCAN_BIST_ERR_INJ_EN
  logic inj_en, inj_en3;
  logic [IW-1:0] inj_idx, inj_idx3;
`endif

  hv_scan_reg_bist #(.RD_LAT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(en1), .i_bist_scan_reg_req(req1),
    .o_scan_reg_bist_ack(ack1), .o_scan_reg_bist_err(err1),
    .o_scan_rd_en(rd_en1), .o_scan_rd_addr(addr1),
    .i_scan_rd_data(d1), .i_scan_rd_data_n(dn1), .i_scan_rd_par(p1),
`ifdef HV_SCAN_BIST_ERR_INJ_EN
    .i_err_inj_en(inj_en), .i_err_inj_idx(inj_idx),
`endif
    .o_err_first_idx(fidx1), .o_err_first_vld(fvld1), .o_err_cnt(cnt1)
  );

  hv_scan_reg_bist #(.RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(en3), .i_bist_scan_reg_req(req3),
    .o_scan_reg_bist_ack(ack3), .o_scan_reg_bist_err(err3),
    .o_scan_rd_en(rd_en3), .o_scan_rd_addr(addr3),
    .i_scan_rd_data(d3), .i_scan_rd_data_n(dn3), .i_scan_rd_par(p3),
`ifdef HV_SCAN_BIST_ERR_INJ_EN
    .i_err_inj_en(inj_en3), .i_err_inj_idx(inj_idx3),
`endif
    .o_err_first_idx(fidx3), .o_err_first_vld(fvld3), .o_err_cnt(cnt3)
  );

  // Register bank model: data is driven only RD_LAT cycles after the strobe,
  // otherwise an all-zero word that fails the check.
  logic [W-1:0] mem_d  [N];
  logic [W-1:0] mem_dn [N];
  logic         mem_p  [N];

  logic          v1;
  logic [IW-1:0] a1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; a1 <= '0;
    end else begin
      v1 <= rd_en1;
      if (rd_en1) a1 <= addr1;
    end
  end
  assign d1  = v1 ? mem_d[a1]  : '0;
  assign dn1 = v1 ? mem_dn[a1] : '0;
  assign p1  = v1 ? mem_p[a1]  : 1'b1;

  logic [2:0]    v3;
  logic [IW-1:0] a3_0, a3_1, a3_2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= '0; a3_0 <= '0; a3_1 <= '0; a3_2 <= '0;
    end else begin
      v3 <= {v3[1:0], rd_en3};
      a3_0 <= addr3; a3_1 <= a3_0; a3_2 <= a3_1;
    end
  end
  assign d3  = v3[2] ? mem_d[a3_2]  : '0;
  assign dn3 = v3[2] ? mem_dn[a3_2] : '0;
  assign p3  = v3[2] ? mem_p[a3_2]  : 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for dut1: expected address per strobe, expected flag per ack.
  int   exp_addr_q [$];
  logic exp_err_q  [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en1) begin
        chk("rd_en_expected", 32'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) chk("rd_addr", 32'(addr1), 32'(exp_addr_q.pop_front()));
      end
      if (ack1) begin
        chk("ack_expected", 32'(exp_err_q.size() > 0), 1);
        if (exp_err_q.size() > 0) chk("ack_err", 32'(err1), 32'(exp_err_q.pop_front()));
      end
    end
  end

  int   m_idx, m_cnt, m_fidx;
  logic m_fvld;

  task automatic model_clear();
    m_idx = 0; m_cnt = 0; m_fidx = 0; m_fvld = 1'b0;
  endtask

  task automatic access1(input logic inj_on, input int inj_i);
    int cyc, rd_cnt, rd_at;
    logic [W-1:0] dd;
    logic e;
    dd = mem_d[m_idx];
    if (inj_on && (m_idx == inj_i)) dd[0] = ~dd[0];
    e = (dd != ~mem_dn[m_idx]) || ((^dd) != mem_p[m_idx]);
    exp_addr_q.push_back(m_idx);
    exp_err_q.push_back(e);
    req1 = 1'b1;
    cyc = 0; rd_cnt = 0; rd_at = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (rd_en1) begin rd_cnt++; rd_at = cyc; end
    end while (!ack1 && cyc < 20);
    req1 = 1'b0;
    chk("ack_latency", 32'(cyc), 3);
    chk("rd_en_count", 32'(rd_cnt), 1);
    chk("rd_en_cycle", 32'(rd_at), 1);
    if (e) begin
      if (!m_fvld) begin m_fvld = 1'b1; m_fidx = m_idx; end
      if (m_cnt < 15) m_cnt++;
    end
    m_idx = (m_idx + 1) % N;
    @(negedge clk);
    chk("ack_pulse", 32'(ack1), 0);
    chk("err_cnt_step", 32'(cnt1), 32'(m_cnt));
    chk("first_step", {fvld1, 28'(fidx1)}, {m_fvld, 28'(m_fidx)});
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] data_n;
    logic         par;
    int           bad_idx;
    logic [W-1:0] bad_dn;
    logic         inj_on;
    int           inj_i;
    int           n_acc;
    int           exp_cnt;
    int           exp_fidx;
    logic         exp_fvld;
  } vec_t;

`ifdef HV_SCAN_BIST_ERR_INJ_EN
  localparam int NV = 5;
`else
  localparam int NV = 4;
`endif
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{8'hA5, 8'h5A, 1'b0, -1, 8'h00, 1'b0, 0,  8,  0, 0, 1'b0};
    vecs[1] = '{8'hA5, 8'h5A, 1'b0,  3, 8'h5B, 1'b0, 0,  8,  1, 3, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, -1, 8'h00, 1'b0, 0, 20, 15, 0, 1'b1};
    vecs[3] = '{8'h3C, 8'hC3, 1'b0,  6, 8'h00, 1'b0, 0, 10,  1, 6, 1'b1};
`ifdef HV_SCAN_BIST_ERR_INJ_EN
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, -1, 8'h00, 1'b1, 5,  8,  1, 5, 1'b1};
    inj_en = 1'b0; inj_idx = '0; inj_en3 = 1'b0; inj_idx3 = '0;
`endif
    for (int i = 0; i < N; i++) begin
      mem_d[i] = 8'hA5; mem_dn[i] = 8'h5A; mem_p[i] = 1'b0;
    end
    rst_n = 1'b0; en1 = 1'b0; req1 = 1'b0; en3 = 1'b0; req3 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_state1", {ack1, err1, rd_en1, addr1, fidx1, fvld1, cnt1}, 0);
    chk("reset_state3", {ack3, err3, rd_en3, addr3, fidx3, fvld3, cnt3}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_d[i]  = vecs[r].data;
        mem_dn[i] = (i == vecs[r].bad_idx) ? vecs[r].bad_dn : vecs[r].data_n;
        mem_p[i]  = vecs[r].par;
      end
`ifdef HV_SCAN_BIST_ERR_INJ_EN
      inj_en  = vecs[r].inj_on;
      inj_idx = IW'(vecs[r].inj_i);
`endif
      en1 = 1'b0;
      repeat (2) @(negedge clk);
      en1 = 1'b1;
      model_clear();
      chk("clear_state", {ack1, rd_en1, fvld1, fidx1, cnt1}, 0);
      for (int a = 0; a < vecs[r].n_acc; a++) access1(vecs[r].inj_on, vecs[r].inj_i);
      chk("final_err_cnt", 32'(cnt1), 32'(vecs[r].exp_cnt));
      chk("final_first_idx", 32'(fidx1), 32'(vecs[r].exp_fidx));
      chk("final_first_vld", 32'(fvld1), 32'(vecs[r].exp_fvld));
      $display("[TB] vector %0d: %0d accesses, err_cnt=%0d first_idx=%0d first_vld=%0d",
               r, vecs[r].n_acc, cnt1, fidx1, fvld1);
    end

`ifdef HV_SCAN_BIST_ERR_INJ_EN
    inj_en = 1'b0;
`endif
    // Abort in WAIT after building up non-zero debug state.
    for (int i = 0; i < N; i++) begin
      mem_d[i] = 8'hA5; mem_dn[i] = (i < 2) ? 8'h00 : 8'h5A; mem_p[i] = 1'b0;
    end
    en1 = 1'b0;
    repeat (2) @(negedge clk);
    en1 = 1'b1;
    model_clear();
    access1(1'b0, 0);
    access1(1'b0, 0);
    chk("pre_abort_cnt", 32'(cnt1), 2);
    exp_addr_q.push_back(2);
    req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en1 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("abort_clear", {ack1, rd_en1, fvld1, fidx1, cnt1}, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_ack", 32'(exp_err_q.size()), 0);
    en1 = 1'b1;
    model_clear();
    @(negedge clk);
    access1(1'b0, 0);
    $display("[TB] abort: resumed at addr 0, err_cnt=%0d", cnt1);

    // RD_LAT=3: req held for 10 cycles, then dropped while the 2nd access is in WAIT.
    for (int i = 0; i < N; i++) begin
      mem_d[i] = 8'hA5; mem_dn[i] = 8'h5A; mem_p[i] = 1'b0;
    end
    en3 = 1'b1;
    @(negedge clk);
    begin
      int ack_n, rd_n, err_n;
      int ack_at [2];
      int rd_at  [2];
      logic [IW-1:0] rd_addr_at [2];
      ack_n = 0; rd_n = 0; err_n = 0;
      ack_at = '{0, 0}; rd_at = '{0, 0}; rd_addr_at = '{0, 0};
      req3 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
        @(negedge clk);
        if (c == 10) req3 = 1'b0;
        if (rd_en3) begin
          if (rd_n < 2) begin rd_at[rd_n] = c; rd_addr_at[rd_n] = addr3; end
          rd_n++;
        end
        if (ack3) begin
          if (ack_n < 2) ack_at[ack_n] = c;
          if (err3) err_n++;
          ack_n++;
        end
      end
      chk("lat3_ack_count", 32'(ack_n), 2);
      chk("lat3_rd_count", 32'(rd_n), 2);
      chk("lat3_ack0_cycle", 32'(ack_at[0]), 5);
      chk("lat3_ack1_cycle", 32'(ack_at[1]), 11);
      chk("lat3_rd0_cycle", 32'(rd_at[0]), 1);
      chk("lat3_rd1_cycle", 32'(rd_at[1]), 7);
      chk("lat3_rd_addrs", {16'(rd_addr_at[0]), 16'(rd_addr_at[1])}, {16'd0, 16'd1});
      chk("lat3_err_flags", 32'(err_n), 0);
      chk("lat3_err_cnt", 32'(cnt3), 0);
      $display("[TB] rd_lat3: acks=%0d at %0d,%0d rd_en=%0d at %0d,%0d",
               ack_n, ack_at[0], ack_at[1], rd_n, rd_at[0], rd_at[1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
